// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - sprite ROM arbiter defaults, requester id type and one-hot helper
package sprite_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 2;
  localparam int ROM_LAT_DEF = 1;

  // id is sized for the largest supported requester count so any N_REQ in 2..8 fits
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  function automatic logic [MAX_REQ-1:0] onehot(input req_id_t id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational requester arbiter; round-robin from last+1, or
// fixed lowest-index priority when SPRITE_ARB_FIXED_PRIO_EN is defined
module rr_arbiter import sprite_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  req_id_t          last,
  output logic [N_REQ-1:0] gnt,
  output req_id_t          win_id
);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    gnt    = '0;
    win_id = '0;
    // scanning downwards leaves the lowest asserted index as the winner
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (((req >> i) & N_REQ'(1)) != '0) begin
        gnt    = N_REQ'(1) << i;
        win_id = req_id_t'(i);
      end
    end
  end
`else
  always_comb begin
    gnt    = '0;
    win_id = '0;
    // walk the search order backwards so the first match after last is written last
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % N_REQ;
      if (((req >> idx) & N_REQ'(1)) != '0) begin
        gnt    = N_REQ'(1) << idx;
        win_id = req_id_t'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares one sprite ROM among N_REQ fetch engines: grant, address
// mux and tagged return pipeline; SPRITE_ARB_FIXED_PRIO_EN selects fixed priority
module sprite_rom_arbiter import sprite_arb_pkg::*; #(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                    vga_clk,
  input  logic                    Reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy
);

  logic                  any;
  req_id_t               win_id;
  req_id_t               last;
  logic [ADDR_W-1:0]     addr_hold;
  logic    [ROM_LAT-1:0] tag_v_q;
  req_id_t [ROM_LAT-1:0] tag_id_q;
  logic    [ROM_LAT:0]   tag_v;
  req_id_t [ROM_LAT:0]   tag_id;
  logic                  unused_tail;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req),
    .last   (last),
    .gnt    (gnt),
    .win_id (win_id)
  );

  assign any = |req;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign last = '0;
`else
  always_ff @(posedge vga_clk) begin
    if (Reset)
      last <= req_id_t'(N_REQ - 1);
    else if (any)
      last <= win_id;
  end
`endif

  assign rom_address = any ? ADDR_W'(addr >> (int'(win_id) * ADDR_W)) : addr_hold;

  always_ff @(posedge vga_clk) begin
    if (Reset)
      addr_hold <= '0;
    else
      addr_hold <= rom_address;
  end

  // stage 0 is this cycle's grant; stage k is the grant issued k cycles ago
  assign tag_v       = {tag_v_q, any};
  assign tag_id      = {tag_id_q, win_id};
  assign unused_tail = tag_v[ROM_LAT] ^ (^tag_id[ROM_LAT]);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
    end else begin
      tag_v_q  <= tag_v[ROM_LAT-1:0];
      tag_id_q <= tag_id[ROM_LAT-1:0];
      busy     <= |tag_v[ROM_LAT-1:0];
      rvalid   <= tag_v[ROM_LAT-1] ? N_REQ'(onehot(tag_id[ROM_LAT-1])) : '0;
      if (tag_v[ROM_LAT-1])
        rdata <= rom_q;
    end
  end

endmodule
